// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the hex display arbiter.
// Owner state, blank segment pattern and one-hot grant encoding.
package hex_disp_pkg;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/displayToHex.sv
// Hex nibble to seven-segment decoder.
// Segment order {g,f,e,d,c,b,a}, active-low.
module displayToHex (
    input  logic [3:0] value,
    output logic [6:0] segments
);

    always_comb begin
        segments = 7'h7F;
        unique case (value)
            4'h0: segments = 7'b1000000;
            4'h1: segments = 7'b1111001;
            4'h2: segments = 7'b0100100;
            4'h3: segments = 7'b0110000;
            4'h4: segments = 7'b0011001;
            4'h5: segments = 7'b0010010;
            4'h6: segments = 7'b0000010;
            4'h7: segments = 7'b1111000;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0010000;
            4'hA: segments = 7'b0001000;
            4'hB: segments = 7'b0000011;
            4'hC: segments = 7'b1000110;
            4'hD: segments = 7'b0100001;
            4'hE: segments = 7'b0000110;
            4'hF: segments = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    int j;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of a shared seven-segment bank with minimum dwell.
// Blanks the bank when nobody owns it.
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DIGITS  = 4,
    parameter int DWELL   = 50_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DIGITS*4-1:0] data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [DIGITS*7-1:0]       HEX
);

    localparam int DW = DIGITS * 4;
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_req
        $error("NUM_REQ must be 2..4");
    end
    if (DIGITS < 1 || DIGITS > 6) begin : g_bad_dig
        $error("DIGITS must be 1..6");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("DWELL must be >= 1");
    end

    state_t            state, state_n;
    logic [NUM_REQ-1:0] grant_n, ack_n;
    logic [DW-1:0]     disp_reg, disp_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [PW-1:0]     rr_ptr, rr_n;
    logic [PW-1:0]     owner, owner_n;
    logic              win_valid;
    logic [PW-1:0]     win, win_nxt;
    logic              take;
    logic [3:0]        oh;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (win_valid),
        .idx   (win)
    );

    assign win_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    assign oh      = onehot(2'(win));

    always_comb begin
        state_n = state;
        grant_n = grant;
        ack_n   = '0;
        disp_n  = disp_reg;
        cnt_n   = cnt;
        rr_n    = rr_ptr;
        owner_n = owner;
        take    = 1'b0;
        unique case (state)
            IDLE: take = win_valid;
            SHOW: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                    if (req[owner]) disp_n = data[int'(owner)*DW +: DW];
                end else if (!win_valid) begin
                    state_n = IDLE;
                    grant_n = '0;
                end else if (win != owner) begin
                    take = 1'b1;
                end else begin
                    cnt_n  = CNT_LOAD;
                    disp_n = data[int'(owner)*DW +: DW];
                end
            end
        endcase
        // New owner: fresh grant, single ack pulse, pointer past the winner.
        if (take) begin
            state_n = SHOW;
            grant_n = oh[NUM_REQ-1:0];
            ack_n   = oh[NUM_REQ-1:0];
            disp_n  = data[int'(win)*DW +: DW];
            cnt_n   = CNT_LOAD;
            rr_n    = win_nxt;
            owner_n = win;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            ack      <= '0;
            disp_reg <= '0;
            cnt      <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            ack      <= ack_n;
            disp_reg <= disp_n;
            cnt      <= cnt_n;
            rr_ptr   <= rr_n;
            owner    <= owner_n;
        end
    end

    assign busy = (state == SHOW);

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        logic [6:0] seg;
        displayToHex u_dec (
            .value    (disp_reg[k*4 +: 4]),
            .segments (seg)
        );
        assign HEX[k*7 +: 7] = busy ? seg : SEG_BLANK;
    end

endmodule
